// File: rtl/pipe_pkg.sv
// Shared types and helpers for the signed delay-line family.
// Latency: n/a (package only).
// Backpressure: n/a; stalls are expressed through each stage's EN input.
package pipe_pkg;

  // Smallest legal number of register stages.
  localparam int DEPTH_MIN = 1;

  // Default sample width used by the fixed-point datapaths.
  localparam int SAMPLE_BW = 9;

  // Stage layout at the default width. Modules with a parameterised width
  // declare the same {data, vld} layout locally, sized by their own BW.
  typedef struct packed {
    logic signed [SAMPLE_BW-1:0] data;
    logic                        vld;
  } stage_t;

  // Ceiling log2 for sizing counters at elaboration time; n must be >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {data, vld} register stage of the delay line.
// Latency: 1 enabled edge from d to q.
// Backpressure: EN=0 holds the stage; FLUSH clears it and wins over EN.
module pipe_stage #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         FLUSH,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Stage register: async clear, then flush, then advance, else hold.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      q <= '0;
    end else if (FLUSH) begin
      q <= '0;
    end else if (EN) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_delay_line.sv
// DEPTH-stage signed delay line with per-stage valid, stall, flush and occupancy.
// Latency: DEPTH enabled edges (or the selected tap when PIPE_DELAY_SEL_EN is defined).
// Backpressure: EN=0 stalls every stage and ignores d; FLUSH empties the line.
module pipe_delay_line
  import pipe_pkg::*;
#(
  parameter int BW    = 9,
  parameter int DEPTH = 4,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic                 FLUSH,
  input  logic signed [BW-1:0] d,
  input  logic                 d_valid,
`ifdef PIPE_DELAY_SEL_EN
  input  logic [CW-1:0]        sel,
`endif
  output logic signed [BW-1:0] q,
  output logic                 q_valid,
  output logic [CW-1:0]        occupancy
);

  // Same {data, vld} layout as pipe_pkg::stage_t, sized by this instance's BW.
  typedef struct packed {
    logic signed [BW-1:0] data;
    logic                 vld;
  } lane_t;

  lane_t stage_d [DEPTH];
  lane_t stage_q [DEPTH];
  lane_t tap;
  logic  exit_vld;
  logic [CW-1:0] vld_count;

  // Stage chain: stage 0 takes the input sample, stage k takes stage k-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_d[k] = '{data: d, vld: d_valid};
    end else begin : g_link
      assign stage_d[k] = stage_q[k-1];
    end
    pipe_stage #(.W(BW + 1)) u_stage (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (EN),
      .FLUSH (FLUSH),
      .d     (stage_d[k]),
      .q     (stage_q[k])
    );
  end

  // The oldest stage is the one discarded on every enabled shift.
  assign exit_vld = stage_q[DEPTH-1].vld;

  // Occupancy tracks entries minus exits; entry and exit together cancel.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      occupancy <= '0;
    end else if (FLUSH) begin
      occupancy <= '0;
    end else if (EN) begin
      if (d_valid && !exit_vld) begin
        occupancy <= occupancy + CW'(1);
      end else if (!d_valid && exit_vld) begin
        occupancy <= occupancy - CW'(1);
      end
    end
  end

  // Population count of the valid bits, the ground truth for occupancy.
  always_comb begin
    vld_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      vld_count = vld_count + CW'(stage_q[k].vld);
    end
  end

`ifdef PIPE_DELAY_SEL_EN
  logic [CW-1:0] tap_idx;

  // Clamp the requested latency into 1..DEPTH and turn it into a stage index.
  always_comb begin
    tap_idx = sel - CW'(1);
    if (sel == '0) begin
      tap_idx = '0;
    end else if (sel > CW'(DEPTH)) begin
      tap_idx = CW'(DEPTH - 1);
    end
  end

  // Output mux over registered stages; sel changes take effect immediately.
  always_comb begin
    tap = stage_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_idx == CW'(k)) tap = stage_q[k];
    end
  end
`else
  assign tap = stage_q[DEPTH-1];
`endif

  assign q       = tap.data;
  assign q_valid = tap.vld;

  a_depth_legal: assert property (@(posedge CLK) DEPTH >= DEPTH_MIN);

  a_occ_range: assert property (@(posedge CLK) disable iff (!RESET)
    occupancy <= CW'(DEPTH));

  a_occ_popcount: assert property (@(posedge CLK) disable iff (!RESET)
    occupancy == vld_count);

endmodule

// File: tb/tb_pipe_delay_line.sv
// Scoreboarded bench for pipe_delay_line (BW=9, DEPTH=4) plus a DEPTH=1 instance.
// Latency: checks each sample emerges after the expected number of enabled edges.
// Backpressure: exercises stall, flush priority and asynchronous reset.
module tb_pipe_delay_line;

  localparam int BW    = 9;
  localparam int DEPTH = 4;

  logic                 CLK;
  logic                 RESET;
  logic                 EN;
  logic                 FLUSH;
  logic signed [BW-1:0] d;
  logic                 d_valid;
  logic signed [BW-1:0] q;
  logic                 q_valid;
  logic [2:0]           occupancy;

  logic                 d1_en;
  logic                 d1_dv;
  logic signed [BW-1:0] d1_d;
  logic signed [BW-1:0] d1_q;
  logic                 d1_qv;
  logic [0:0]           d1_occ;

`ifdef PIPE_DELAY_SEL_EN
  logic [2:0] sel;
  logic [0:0] d1_sel;
`endif

  pipe_delay_line #(.BW(BW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .EN        (EN),
    .FLUSH     (FLUSH),
    .d         (d),
    .d_valid   (d_valid),
`ifdef PIPE_DELAY_SEL_EN
    .sel       (sel),
`endif
    .q         (q),
    .q_valid   (q_valid),
    .occupancy (occupancy)
  );

  pipe_delay_line #(.BW(BW), .DEPTH(1)) dut_d1 (
    .CLK       (CLK),
    .RESET     (RESET),
    .EN        (d1_en),
    .FLUSH     (1'b0),
    .d         (d1_d),
    .d_valid   (d1_dv),
`ifdef PIPE_DELAY_SEL_EN
    .sel       (d1_sel),
`endif
    .q         (d1_q),
    .q_valid   (d1_qv),
    .occupancy (d1_occ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic signed [BW-1:0] d;
    logic                 v;
    int                   due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   en_edges = 0;
  int   last_due = -1;
  int   lat      = DEPTH;

  // Every sample accepted by an enabled edge is expected back after lat edges.
  always @(posedge CLK) begin
    if (!RESET) begin
      sb.delete();
    end else if (FLUSH) begin
      sb.delete();
    end else if (EN) begin
      en_edges++;
      sb.push_back('{d: d, v: d_valid, due: en_edges + lat - 1});
    end
  end

  // Monitor: compare the output whenever an expected sample is due.
  always @(negedge CLK) begin
    if (RESET) begin
      if (sb.size() > 0 && sb[0].due == en_edges) begin
        mon_e = sb.pop_front();
        chk($sformatf("sb_q[due %0d]", mon_e.due), $signed(q), $signed(mon_e.d));
        chk($sformatf("sb_qv[due %0d]", mon_e.due), q_valid, mon_e.v);
        last_due = mon_e.due;
      end else if (q_valid && last_due != en_edges) begin
        chk("sb_unexpected_valid", q_valid, 0);
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    bit en;
    bit fl;
    bit dv;
    int d;
    int occ;
    bit cq;
    bit qv;
    int q;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t V(bit en, bit fl, bit dv, int dd, int occ,
                             bit cq = 1'b0, bit qv = 1'b0, int qq = 0);
    vec_t v;
    v.en = en; v.fl = fl; v.dv = dv; v.d = dd; v.occ = occ;
    v.cq = cq; v.qv = qv; v.q = qq;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_tab(input string name);
    int dd;
    for (int i = 0; i < tab.size(); i++) begin
      dd      = tab[i].d;
      EN      = tab[i].en;
      FLUSH   = tab[i].fl;
      d_valid = tab[i].dv;
      d       = dd[BW-1:0];
      step();
      chk($sformatf("%s[%0d].occ", name, i), occupancy, tab[i].occ);
      if (tab[i].cq) begin
        chk($sformatf("%s[%0d].qv", name, i), q_valid, tab[i].qv);
        chk($sformatf("%s[%0d].q", name, i), $signed(q), tab[i].q);
      end
    end
    tab.delete();
    EN = 1'b0; FLUSH = 1'b0; d_valid = 1'b0; d = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; EN = 1'b0; FLUSH = 1'b0; d = '0; d_valid = 1'b0;
    d1_en = 1'b0; d1_dv = 1'b0; d1_d = '0;
`ifdef PIPE_DELAY_SEL_EN
    sel = 3'd4; d1_sel = 1'b0;
`endif
    repeat (2) step();
    chk("reset_q", $signed(q), 0);
    chk("reset_qv", q_valid, 0);
    chk("reset_occ", occupancy, 0);
    RESET = 1'b1;

    // Fill all four stages, then reset mid-cycle.
    tab.push_back(V(1, 0, 1, 11, 1));
    tab.push_back(V(1, 0, 1, 22, 2));
    tab.push_back(V(1, 0, 1, 33, 3));
    tab.push_back(V(1, 0, 1, 44, 4, 1, 1, 11));
    run_tab("fill");
    #2 RESET = 1'b0;
    #1;
    chk("areset_q", $signed(q), 0);
    chk("areset_qv", q_valid, 0);
    chk("areset_occ", occupancy, 0);
    step();
    RESET = 1'b1;

    // First sample after release emerges exactly 4 edges later.
    tab.push_back(V(1, 0, 1, 100, 1, 1, 0, 0));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 0, 0));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 0, 0));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 1, 100));
    run_tab("post_reset");

    // Flush with EN low still empties, then stream with stalls.
    tab.push_back(V(0, 1, 1, 50, 0, 1, 0, 0));
    tab.push_back(V(1, 0, 1, -256, 1));
    tab.push_back(V(1, 0, 1, 255, 2));
    tab.push_back(V(0, 0, 1, 99, 2, 1, 0, 0));
    tab.push_back(V(0, 0, 0, 99, 2, 1, 0, 0));
    tab.push_back(V(0, 0, 1, 99, 2, 1, 0, 0));
    tab.push_back(V(1, 0, 1, -1, 3));
    tab.push_back(V(1, 0, 1, 7, 4, 1, 1, -256));
    tab.push_back(V(0, 0, 1, 5, 4, 1, 1, -256));
    tab.push_back(V(0, 0, 0, 5, 4, 1, 1, -256));
    tab.push_back(V(1, 0, 0, 3, 3, 1, 1, 255));
    tab.push_back(V(1, 0, 0, -2, 2, 1, 1, -1));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 1, 7));
    tab.push_back(V(1, 0, 0, 0, 0, 1, 0, 3));
    run_tab("stall");

    // Flush beats EN and d_valid; nothing valid emerges afterwards.
    tab.push_back(V(1, 0, 1, 10, 1));
    tab.push_back(V(1, 0, 1, 20, 2));
    tab.push_back(V(1, 0, 1, 30, 3));
    tab.push_back(V(1, 1, 1, 77, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) tab.push_back(V(1, 0, 0, 0, 0, 1, 0, 0));
    run_tab("flush");

    // Occupancy walk: valid pattern 1,0,1,1,1,1,0,0,0,0.
    tab.push_back(V(1, 0, 1, 1, 1));
    tab.push_back(V(1, 0, 0, -2, 1));
    tab.push_back(V(1, 0, 1, 3, 2));
    tab.push_back(V(1, 0, 1, -4, 3));
    tab.push_back(V(1, 0, 1, 5, 3));
    tab.push_back(V(1, 0, 1, -6, 4));
    tab.push_back(V(1, 0, 0, 7, 3));
    tab.push_back(V(1, 0, 0, -8, 2));
    tab.push_back(V(1, 0, 0, 9, 1));
    tab.push_back(V(1, 0, 0, -10, 0));
    for (int i = 0; i < 4; i++) tab.push_back(V(1, 0, 0, 0, 0));
    run_tab("occ");

`ifdef PIPE_DELAY_SEL_EN
    // Runtime tap: sel=0 -> latency 1, sel=2 -> 2, sel=7 -> clamped to 4.
    tab.push_back(V(0, 1, 0, 0, 0, 1, 0, 0));
    run_tab("sel_flush0");
    sel = 3'd0; lat = 1;
    tab.push_back(V(1, 0, 1, -256, 1, 1, 1, -256));
    run_tab("sel0");
    tab.push_back(V(0, 1, 0, 0, 0, 1, 0, 0));
    run_tab("sel_flush2");
    sel = 3'd2; lat = 2;
    tab.push_back(V(1, 0, 1, -256, 1, 1, 0, 0));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 1, -256));
    run_tab("sel2");
    tab.push_back(V(0, 1, 0, 0, 0, 1, 0, 0));
    run_tab("sel_flush7");
    sel = 3'd7; lat = 4;
    tab.push_back(V(1, 0, 1, -256, 1, 1, 0, 0));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 0, 0));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 0, 0));
    tab.push_back(V(1, 0, 0, 0, 1, 1, 1, -256));
    run_tab("sel7");
    tab.push_back(V(0, 1, 0, 0, 0, 1, 0, 0));
    run_tab("sel_restore");
    sel = 3'd4; lat = 4;
`endif

    // DEPTH=1 instance: alternate EN with ramp data, a plain enabled register.
    begin
      int d1_in[6]  = '{-8, -5, -2, 1, 4, 7};
      int d1_exp[6] = '{-8, -8, -2, -2, 4, 4};
      int v;
      d1_dv = 1'b1;
      for (int i = 0; i < 6; i++) begin
        v     = d1_in[i];
        d1_d  = v[BW-1:0];
        d1_en = (i % 2 == 0);
        step();
        chk($sformatf("d1[%0d].q", i), $signed(d1_q), d1_exp[i]);
        chk($sformatf("d1[%0d].qv", i), d1_qv, 1);
        chk($sformatf("d1[%0d].occ", i), d1_occ, 1);
      end
      d1_en = 1'b0; d1_dv = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
